// File: rtl/tone_pkg.sv
// Shared types and tone constants for the note sequencer.
// Divider values are half-period counts at CLK_HZ: NOTE_x = CLK_HZ/(2*f)-1.
package tone_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

   localparam int unsigned CLK_HZ   = 48_000_000;

   localparam int unsigned NOTE_C4  = CLK_HZ / (2 * 262) - 1;
   localparam int unsigned NOTE_D4  = CLK_HZ / (2 * 294) - 1;
   localparam int unsigned NOTE_E4  = CLK_HZ / (2 * 330) - 1;
   localparam int unsigned NOTE_F4  = CLK_HZ / (2 * 349) - 1;
   localparam int unsigned NOTE_G4  = CLK_HZ / (2 * 392) - 1;
   localparam int unsigned NOTE_A4  = CLK_HZ / (2 * 440) - 1;
   localparam int unsigned NOTE_B4  = CLK_HZ / (2 * 494) - 1;
   localparam int unsigned NOTE_C5  = CLK_HZ / (2 * 523) - 1;

   localparam int unsigned REST     = 0;
   localparam int unsigned END_MARK = 0;

   function automatic int unsigned note_div(input int unsigned f_hz);
      return CLK_HZ / (2 * f_hz) - 1;
   endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control, table-write and status bundle for note_sequencer.
// The sequencer takes the slave side; the controller drives the master side.
interface note_sequencer_if #(
   parameter int IDX_W = 4,
   parameter int DIV_W = 18,
   parameter int DUR_W = 8
);
   logic             start;
   logic             stop;
   logic             loop_en;
   logic             wr_en;
   logic [IDX_W-1:0] wr_addr;
   logic [DIV_W-1:0] wr_div;
   logic [DUR_W-1:0] wr_dur;
   logic             busy;
   logic             done;
   logic [IDX_W-1:0] note_idx;
   logic             speaker;

   modport master (
      output start, stop, loop_en, wr_en, wr_addr, wr_div, wr_dur,
      input  busy, done, note_idx, speaker
   );

   modport slave (
      input  start, stop, loop_en, wr_en, wr_addr, wr_div, wr_dur,
      output busy, done, note_idx, speaker
   );
endinterface

// File: rtl/tone_divider.sv
// Half-period down-counter and speaker toggle; div==0 holds the output low (rest).
// load restarts the count from div with the output cleared.
module tone_divider #(
   parameter int DIV_W = 18
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   output logic             sq
);
   logic [DIV_W-1:0] r_cnt;
   logic             r_sq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_sq  <= 1'b0;
      end else if (load) begin
         r_cnt <= div;
         r_sq  <= 1'b0;
      end else if (en) begin
         if (div == '0) begin
            r_cnt <= '0;
            r_sq  <= 1'b0;
         end else if (r_cnt == '0) begin
            r_cnt <= div;
            r_sq  <= ~r_sq;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign sq = r_sq;
endmodule

// File: rtl/note_sequencer.sv
// Melody player: note table, FSM, tick prescaler and duration counter.
// Define NOTE_GAP_EN to insert a silent GAP_TICKS articulation gap after each note.
module note_sequencer #(
   parameter int NUM_NOTES = 16,
   parameter int DIV_W     = 18,
   parameter int DUR_W     = 8,
   parameter int TICK_DIV  = 480000,
   parameter int GAP_TICKS = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   note_sequencer_if.slave bus
);
   import tone_pkg::*;

   localparam int IDX_W = $clog2(NUM_NOTES);
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_NOTES - 1);
   localparam logic [DUR_W-1:0] GAP_DUR = DUR_W'(GAP_TICKS);
   localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

   logic [DIV_W-1:0] r_mem_div [NUM_NOTES];
   logic [DUR_W-1:0] r_mem_dur [NUM_NOTES];

   state_t           r_state, w_state_n;
   logic [IDX_W-1:0] r_idx,   w_idx_n;
   logic [DIV_W-1:0] r_div,   w_div_n;
   logic [DUR_W-1:0] r_dur,   w_dur_n;
   logic [PRE_W-1:0] r_pre,   w_pre_n;
   logic [DIV_W-1:0] w_rd_div, w_tone_div;
   logic [DUR_W-1:0] w_rd_dur;
   logic             w_tick, w_adv, w_sq;

   // Table is plain storage; a same-cycle write and LOAD read sees the old entry.
   always_ff @(posedge clk) begin
      if (bus.wr_en) begin
         r_mem_div[bus.wr_addr] <= bus.wr_div;
         r_mem_dur[bus.wr_addr] <= bus.wr_dur;
      end
   end

   assign w_rd_div = r_mem_div[r_idx];
   assign w_rd_dur = r_mem_dur[r_idx];
   assign w_tick   = (r_pre == PRE_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_div   <= '0;
         r_dur   <= '0;
         r_pre   <= '0;
      end else begin
         r_state <= w_state_n;
         r_idx   <= w_idx_n;
         r_div   <= w_div_n;
         r_dur   <= w_dur_n;
         r_pre   <= w_pre_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_idx_n   = r_idx;
      w_div_n   = r_div;
      w_dur_n   = r_dur;
      w_pre_n   = r_pre;
      w_adv     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               w_state_n = LOAD;
               w_idx_n   = '0;
            end
         end
         LOAD: begin
            w_div_n = w_rd_div;
            w_dur_n = w_rd_dur;
            w_pre_n = '0;
            if (w_rd_dur == '0) begin
               // Looping from an end marker at entry 0 would spin forever.
               if (bus.loop_en && r_idx != '0) begin
                  w_idx_n = '0;
               end else begin
                  w_state_n = DONE;
               end
            end else begin
               w_state_n = PLAY;
            end
         end
         PLAY: begin
            w_pre_n = w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
               w_dur_n = r_dur - 1'b1;
               if (r_dur == DUR_ONE) begin
`ifdef NOTE_GAP_EN
                  w_state_n = GAP;
                  w_dur_n   = GAP_DUR;
`else
                  w_adv     = 1'b1;
`endif
               end
            end
         end
         GAP: begin
            w_pre_n = w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
               w_dur_n = r_dur - 1'b1;
               if (r_dur == DUR_ONE) w_adv = 1'b1;
            end
         end
         DONE:    w_state_n = IDLE;
         default: w_state_n = IDLE;
      endcase

      if (w_adv) begin
         if (r_idx == IDX_MAX) begin
            if (bus.loop_en) begin
               w_idx_n   = '0;
               w_state_n = LOAD;
            end else begin
               w_state_n = DONE;
            end
         end else begin
            w_idx_n   = r_idx + 1'b1;
            w_state_n = LOAD;
         end
      end

      if (bus.stop && r_state != IDLE) begin
         w_state_n = IDLE;
         w_idx_n   = r_idx;
      end
   end

   // The divider latches the fresh table entry on the LOAD edge, before r_div settles.
   assign w_tone_div = (r_state == LOAD) ? w_rd_div : r_div;

   tone_divider #(.DIV_W(DIV_W)) u_tone (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (r_state == PLAY),
      .load  (r_state == LOAD),
      .div   (w_tone_div),
      .sq    (w_sq)
   );

   assign bus.busy     = (r_state != IDLE);
   assign bus.done     = (r_state == DONE);
   assign bus.note_idx = r_idx;
   assign bus.speaker  = w_sq & (r_state == PLAY);
endmodule

// File: tb/tb_note_sequencer.sv
// Cycle-accurate scoreboard bench for note_sequencer (TICK_DIV=4, NUM_NOTES=4, GAP_TICKS=1).
module tb_note_sequencer;
   localparam int TICK = 4;
   localparam int GAPT = 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   note_sequencer_if #(.IDX_W(2), .DIV_W(18), .DUR_W(8)) bus ();

   note_sequencer #(
      .NUM_NOTES (4),
      .DIV_W     (18),
      .DUR_W     (8),
      .TICK_DIV  (TICK),
      .GAP_TICKS (GAPT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic       busy;
      logic       done;
      logic       spk;
      logic [1:0] idx;
   } exp_t;

   exp_t  sb[$];
   int    n_cmp = 0;
   int    n_err = 0;
   string tname = "reset";

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s.%s @%0t: got %0h, expected %0h", tname, tag, $time, act, exp);
      end
   endtask

   task automatic push(input logic b, input logic d, input logic s, input logic [1:0] i);
      exp_t e;
      e.busy = b; e.done = d; e.spk = s; e.idx = i;
      sb.push_back(e);
   endtask

   // LOAD cycle, then dur*TICK PLAY cycles toggling every div+1 clocks.
   task automatic push_note(input int i, input int div, input int dur);
      push(1'b1, 1'b0, 1'b0, 2'(i));
      for (int k = 0; k < dur * TICK; k++)
         push(1'b1, 1'b0, (div == 0) ? 1'b0 : 1'((k / (div + 1)) % 2), 2'(i));
`ifdef NOTE_GAP_EN
      for (int k = 0; k < GAPT * TICK; k++)
         push(1'b1, 1'b0, 1'b0, 2'(i));
`endif
   endtask

   // LOAD of an end marker, DONE pulse, back to IDLE.
   task automatic push_end(input int i);
      push(1'b1, 1'b0, 1'b0, 2'(i));
      push(1'b1, 1'b1, 1'b0, 2'(i));
      push(1'b0, 1'b0, 1'b0, 2'(i));
   endtask

   task automatic check_item();
      exp_t e;
      e = sb.pop_front();
      chk("busy",     32'(bus.busy),     32'(e.busy));
      chk("done",     32'(bus.done),     32'(e.done));
      chk("speaker",  32'(bus.speaker),  32'(e.spk));
      chk("note_idx", 32'(bus.note_idx), 32'(e.idx));
   endtask

   // One scoreboard entry per cycle; act 1 drops loop_en, act 2 pulses stop.
   task automatic drain(input int act_at, input int act);
      int n = 0;
      while (sb.size() > 0) begin
         check_item();
         if (sb.size() == 0) break;
         if (n == act_at && act == 1) bus.loop_en = 1'b0;
         if (n == act_at && act == 2) bus.stop = 1'b1;
         if (n == act_at + 1) bus.stop = 1'b0;
         n++;
         @(negedge clk);
      end
   endtask

   task automatic wr(input int a, input int div, input int dur);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 2'(a);
      bus.wr_div  = 18'(div);
      bus.wr_dur  = 8'(dur);
      @(negedge clk);
      bus.wr_en   = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   initial begin
      int len1;
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.stop    = 1'b0;
      bus.loop_en = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_div  = '0;
      bus.wr_dur  = '0;
      @(negedge clk);
      push(1'b0, 1'b0, 1'b0, 2'd0);
      check_item();
      rst_n = 1'b1;
      @(negedge clk);

      tname = "single";
      wr(0, 3, 2);
      wr(1, 0, 0);
      push_note(0, 3, 2);
      push_end(1);
      pulse_start();
      drain(-1, 0);

      tname = "rest";
      wr(0, 0, 3);
      push_note(0, 0, 3);
      push_end(1);
      pulse_start();
      drain(-1, 0);

      tname = "wrap";
      for (int i = 0; i < 4; i++) wr(i, 1, 1);
      bus.loop_en = 1'b1;
      for (int i = 0; i < 4; i++) push_note(i, 1, 1);
      len1 = sb.size();
      for (int i = 0; i < 4; i++) push_note(i, 1, 1);
      push(1'b1, 1'b1, 1'b0, 2'd3);
      push(1'b0, 1'b0, 1'b0, 2'd3);
      pulse_start();
      drain(len1 + 2, 1);

      tname = "end0_loop";
      wr(0, 5, 0);
      bus.loop_en = 1'b1;
      push_end(0);
      pulse_start();
      drain(-1, 0);
      bus.loop_en = 1'b0;

      tname = "stop_play";
      wr(0, 1, 2);
      push(1'b1, 1'b0, 1'b0, 2'd0);
      for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 1'((k / 2) % 2), 2'd0);
      for (int k = 0; k < 3; k++) push(1'b0, 1'b0, 1'b0, 2'd0);
      pulse_start();
      drain(4, 2);

      tname = "start_stop";
      for (int k = 0; k < 4; k++) push(1'b0, 1'b0, 1'b0, 2'd0);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      drain(-1, 0);

      tname = "async_rst";
      wr(0, 1, 4);
      push(1'b1, 1'b0, 1'b0, 2'd0);
      for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 1'((k / 2) % 2), 2'd0);
      pulse_start();
      drain(-1, 0);
      #2 rst_n = 1'b0;
      #1;
      push(1'b0, 1'b0, 1'b0, 2'd0);
      check_item();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push(1'b0, 1'b0, 1'b0, 2'd0);
      check_item();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
